// File: rtl/counter_monitor_if.sv
// Stream and status bundle between a counter source and counter_monitor.
//   master: drives in_valid, in_y, clear_err; observes the monitor status.
//   slave : the monitor; observes the stream, drives locked/err/err_sticky/
//           err_count/have_prev/exp_y.
interface counter_monitor_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_y;
  logic             clear_err;
  logic             locked;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic             have_prev;
  logic [WIDTH-1:0] exp_y;

  modport master (
    output in_valid, in_y, clear_err,
    input  locked, err, err_sticky, err_count, have_prev, exp_y
  );

  modport slave (
    input  in_valid, in_y, clear_err,
    output locked, err, err_sticky, err_count, have_prev, exp_y
  );
endinterface

// File: rtl/counter_monitor.sv
// counter_monitor: checks that a sampled counter stream advances by STEP
// (mod 2^WIDTH) per valid sample; locks after LOCK_N good increments and then
// reports violations as a pulse, a sticky flag and a saturating count.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   mon      : slave side of counter_monitor_if (stream in, status out)
module counter_monitor #(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] STEP   = WIDTH'(1),
  parameter int unsigned      LOCK_N = 4,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  counter_monitor_if.slave   mon
);

  localparam int unsigned      RUN_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             have_prev_q, have_prev_d;
  logic             locked_q, err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             match_c, last_good_c;

  // exp_q always holds prev + STEP, so the match test is a single compare.
  assign match_c     = (mon.in_y == exp_q);
  assign last_good_c = ((RUN_W+1)'(good_run_q) + (RUN_W+1)'(1)) == (RUN_W+1)'(LOCK_N);

  // Next-state and status logic.
  always_comb begin
    state_d     = state_q;
    good_run_d  = good_run_q;
    exp_d       = exp_q;
    have_prev_d = have_prev_q;
    err_d       = 1'b0;
    sticky_d    = mon.clear_err ? 1'b0 : sticky_q;
    cnt_base    = mon.clear_err ? '0 : cnt_q;
    cnt_d       = cnt_base;

    if (mon.in_valid) begin
      exp_d = WIDTH'(mon.in_y + STEP);
      unique case (state_q)
        IDLE: begin
          have_prev_d = 1'b1;
          good_run_d  = '0;
          state_d     = ACQ;
        end
        ACQ: begin
          if (!match_c) begin
            good_run_d = '0;
          end else if (last_good_c) begin
            good_run_d = '0;
            state_d    = LOCKED;
          end else begin
            good_run_d = RUN_W'(good_run_q + RUN_W'(1));
          end
        end
        LOCKED: begin
          if (!match_c) begin
            // A violation in the same cycle as clear_err still counts once.
            err_d      = 1'b1;
            sticky_d   = 1'b1;
            cnt_d      = (cnt_base == CNT_MAX) ? cnt_base : CNT_W'(cnt_base + CNT_W'(1));
            good_run_d = '0;
            state_d    = ACQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; locked is registered from the next state so it falls
  // in the same cycle err rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      good_run_q  <= '0;
      exp_q       <= STEP;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      exp_q       <= exp_d;
      have_prev_q <= have_prev_d;
      locked_q    <= (state_d == LOCKED);
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mon.locked     = locked_q;
  assign mon.err        = err_q;
  assign mon.err_sticky = sticky_q;
  assign mon.err_count  = cnt_q;
  assign mon.have_prev  = have_prev_q;
  assign mon.exp_y      = exp_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor: directed scenarios plus a random
// stream, all checked against a streak-based reference model.
module tb_counter_monitor;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WIDTH-1:0] STEP = 64'd1;
  localparam int unsigned VW = 3 + CNT_W + 1 + WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  counter_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  counter_monitor #(.WIDTH(WIDTH), .STEP(STEP), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: locked means the current run of consecutive matches
  // since the last capture or mismatch has reached LOCK_N.
  logic             m_have, m_locked, m_err, m_sticky;
  logic [WIDTH-1:0] m_prev;
  logic [CNT_W-1:0] m_cnt;
  int               m_streak;

  function automatic logic [VW-1:0] model_vec();
    return {m_locked, m_err, m_sticky, m_cnt, m_have, m_prev + STEP};
  endfunction

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.locked, bus.err, bus.err_sticky, bus.err_count, bus.have_prev, bus.exp_y};

  task automatic model_step(input logic r, input logic v, input logic [WIDTH-1:0] y, input logic c);
    if (r) begin
      m_have = 0; m_locked = 0; m_err = 0; m_sticky = 0; m_cnt = '0; m_prev = '0; m_streak = 0;
    end else begin
      m_err = 0;
      if (c) begin m_sticky = 0; m_cnt = '0; end
      if (v) begin
        if (!m_have) begin
          m_have = 1; m_streak = 0;
        end else if (y == m_prev + STEP) begin
          m_streak++;
        end else begin
          if (m_locked) begin
            m_err = 1; m_sticky = 1;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
          end
          m_streak = 0;
        end
        m_prev   = y;
        m_locked = (m_streak >= int'(LOCK_N));
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, settle past the edge.
  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] y, input logic c);
    rst = r; bus.in_valid = v; bus.in_y = y; bus.clear_err = c;
    @(posedge clk);
    model_step(r, v, y, c);
    #1;
    rst = 0; bus.in_valid = 0; bus.clear_err = 0;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, 0);
    n_cmp++;
    if (dut_vec !== {3'b000, {CNT_W{1'b0}}, 1'b0, STEP}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, {3'b000, {CNT_W{1'b0}}, 1'b0, STEP});
    end
  endtask

  task automatic test_acquire();
    drive(1, 0, '0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 64'(10 + i), 0);
      n_cmp++;
      if (bus.have_prev !== 1'b1 || bus.err !== 1'b0) begin
        n_fail++; $display("FAIL acq_have_err i=%0d: have=%b err=%b want 1 0", i, bus.have_prev, bus.err);
      end
      n_cmp++;
      if (bus.locked !== (i >= 4)) begin
        n_fail++; $display("FAIL acq_locked i=%0d: got %b want %b", i, bus.locked, (i >= 4));
      end
    end
    n_cmp++;
    if (bus.exp_y !== 64'd16) begin
      n_fail++; $display("FAIL acq_exp: got %0d want 16", bus.exp_y);
    end
  endtask

  task automatic test_violation();
    drive(1, 0, '0, 0);
    for (int i = 100; i <= 105; i++) drive(0, 1, 64'(i), 0);
    drive(0, 1, 64'd107, 0);
    n_cmp++;
    if ({bus.err, bus.locked, bus.err_sticky, bus.err_count, bus.exp_y} !== {3'b101, 16'd1, 64'd108}) begin
      n_fail++; $display("FAIL viol_pulse: err=%b locked=%b sticky=%b cnt=%0d exp=%0d want 1 0 1 1 108",
                         bus.err, bus.locked, bus.err_sticky, bus.err_count, bus.exp_y);
    end
    drive(0, 0, '0, 0);
    n_cmp++;
    if (bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL viol_one_cycle: err=%b sticky=%b want 0 1", bus.err, bus.err_sticky);
    end
    for (int i = 108; i <= 111; i++) begin
      drive(0, 1, 64'(i), 0);
      n_cmp++;
      if (bus.locked !== (i == 111)) begin
        n_fail++; $display("FAIL relock y=%0d: got %b want %b", i, bus.locked, (i == 111));
      end
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] y;
    drive(1, 0, '0, 0);
    y = 64'hFFFF_FFFF_FFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, y, 0);
      n_cmp++;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wrap_err i=%0d: got %b want 0", i, bus.err); end
      y = y + 64'd1;
    end
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.exp_y !== 64'd2) begin
      n_fail++; $display("FAIL wrap_lock: locked=%b exp=%h want 1 2", bus.locked, bus.exp_y);
    end
  endtask

  task automatic test_gaps();
    logic [VW-1:0] held;
    drive(1, 0, '0, 0);
    for (int i = 5; i <= 9; i++) begin
      drive(0, 1, 64'(i), 0);
      held = dut_vec;
      n_cmp++;
      if (bus.locked !== (i == 9)) begin
        n_fail++; $display("FAIL gap_lock y=%0d: got %b want %b", i, bus.locked, (i == 9));
      end
      for (int g = 0; g < 3; g++) begin
        drive(0, 0, 64'hDEAD, 0);
        n_cmp++;
        if (dut_vec !== model_vec() || dut_vec !== held) begin
          n_fail++; $display("FAIL gap_hold y=%0d g=%0d: got %h want %h", i, g, dut_vec, model_vec());
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] y;
    drive(1, 0, '0, 0);
    y = 64'd0;
    drive(0, 1, y, 0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin y = y + 64'd1; drive(0, 1, y, 0); end
      y = y + 64'd5;
      drive(0, 1, y, (k == 3));
      n_cmp++;
      if (bus.err_count !== ((k == 3) ? 16'd1 : 16'(k + 1)) || bus.err_sticky !== 1'b1) begin
        n_fail++; $display("FAIL simul_cnt k=%0d: cnt=%0d sticky=%b want %0d 1",
                           k, bus.err_count, bus.err_sticky, (k == 3) ? 1 : k + 1);
      end
    end
    for (int j = 0; j < 4; j++) begin y = y + 64'd1; drive(0, 1, y, 0); end
    drive(0, 0, '0, 1);
    n_cmp++;
    if ({bus.err_count, bus.err_sticky, bus.locked} !== {16'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL clear_only: cnt=%0d sticky=%b locked=%b want 0 0 1",
                         bus.err_count, bus.err_sticky, bus.locked);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, '0, 0);
    for (int i = 0; i <= 4; i++) drive(0, 1, 64'(i), 0);
    drive(0, 1, 64'd50, 0);
    for (int i = 51; i <= 54; i++) drive(0, 1, 64'(i), 0);
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: locked=%b sticky=%b want 1 1", bus.locked, bus.err_sticky);
    end
    drive(1, 1, 64'd55, 1);
    n_cmp++;
    if (dut_vec !== {3'b000, {CNT_W{1'b0}}, 1'b0, STEP}) begin
      n_fail++; $display("FAIL mid_reset: got %h want %h", dut_vec, {3'b000, {CNT_W{1'b0}}, 1'b0, STEP});
    end
    drive(0, 1, 64'd500, 0);
    n_cmp++;
    if ({bus.err, bus.have_prev, bus.locked, bus.exp_y} !== {3'b010, 64'd501}) begin
      n_fail++; $display("FAIL mid_capture: err=%b have=%b locked=%b exp=%0d want 0 1 0 501",
                         bus.err, bus.have_prev, bus.locked, bus.exp_y);
    end
    for (int i = 501; i <= 504; i++) begin
      drive(0, 1, 64'(i), 0);
      n_cmp++;
      if (bus.locked !== (i == 504)) begin
        n_fail++; $display("FAIL mid_relock y=%0d: got %b want %b", i, bus.locked, (i == 504));
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] y;
    logic             r, v, c;
    int               sel;
    drive(1, 0, '0, 0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 249) == 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 24) == 0);
      sel = int'($urandom_range(0, 19));
      if (sel < 16)      y = m_prev + STEP;
      else if (sel < 18) y = {$urandom, $urandom};
      else               y = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      drive(r, v, y, c);
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random n=%0d: got %h want %h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_y = '0; bus.clear_err = 0;
    model_step(1, 0, '0, 0);
    test_reset();
    test_acquire();
    test_violation();
    test_wrap();
    test_gaps();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Consumer-side checker for the free-running counter stream.
- Samples a WIDTH-bit count value whenever in_valid is high.
- Checks that each sample equals the previous sample plus STEP, modulo 2^WIDTH.
- Acquires lock after LOCK_N consecutive good increments, then flags increment violations with a pulse, a sticky flag and a saturating error counter.
- Sits downstream of the counter block and also serves as the runtime twin of its formal increment property.

Parameters:
- WIDTH, 64: width of the observed count value.
- STEP, 1: expected increment per valid sample (WIDTH bits, non-zero).
- LOCK_N, 4: consecutive good increments required to enter LOCKED (range 1..255).
- CNT_W, 16: width of err_count.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: in_y is valid this cycle.
- in_y, input, WIDTH: observed counter value.
- clear_err, input, 1: clears err_sticky and err_count.
- locked, output, 1: high while the FSM is in LOCKED.
- err, output, 1: one-cycle pulse on an increment violation while LOCKED.
- err_sticky, output, 1: set by err, held until clear_err or rst.
- err_count, output, CNT_W: saturating count of violations.
- have_prev, output, 1: a previous sample is held.
- exp_y, output, WIDTH: expected next value, (prev + STEP) mod 2^WIDTH; only meaningful when have_prev = 1.

Behaviour:
- All outputs are registered. On rst, at the clk edge: state = IDLE, prev = 0, good_run = 0, locked = 0, err = 0, err_sticky = 0, err_count = 0, have_prev = 0, exp_y = STEP.
- rst dominates every other input.
- match = (in_y == prev + STEP), computed in WIDTH bits, so wrap is legal: all-ones + 1 = 0 is a match.
- Response latency: an in_valid sample in cycle N updates outputs visible in cycle N+1.
- in_valid low: all state holds and err is 0. Gaps of any length are allowed; there is no timeout.
- FSM states:
  - IDLE: on in_valid, prev <= in_y, have_prev <= 1, good_run <= 0, go to ACQ. No check is performed.
  - ACQ, on in_valid with match: good_run++. If good_run + 1 == LOCK_N, go to LOCKED and clear good_run.
  - ACQ, on in_valid with mismatch: good_run <= 0, stay in ACQ, no err (resync only).
  - LOCKED, on in_valid with match: stay.
  - LOCKED, on in_valid with mismatch: err = 1 for exactly one cycle, err_sticky <= 1, err_count <= err_count + 1 (saturating at all-ones), go to ACQ with good_run = 0.
  - In ACQ and LOCKED, prev <= in_y on every valid sample, match or not.
- locked = (state == LOCKED). It drops in the same cycle that err rises.
- clear_err: err_sticky <= 0 and err_count <= 0 at the next edge.
  - If a new violation occurs in the same cycle, the violation wins: err_sticky = 1, err_count = 1.
  - clear_err has no effect on the FSM, prev or locked.
- Mid-stream rst: returns to IDLE, and the next valid sample is captured without a check.
- LOCK_N = 1: the first match after IDLE locks.

Test Plan:
- Reset then 6 valid samples 10, 11, 12, 13, 14, 15 (STEP = 1, LOCK_N = 4) -> have_prev = 1 after the 10 sample; locked = 1 in the cycle after the 14 sample; err = 0 throughout; exp_y = 16 at the end.
- Locked stream 100..105, then sample 107 -> err = 1 for one cycle only; locked = 0 in that same cycle; err_sticky = 1; err_count = 1; exp_y = 108. Then 108, 109, 110, 111 -> relock after 111.
- Wrap: samples 0xFFFF_FFFF_FFFF_FFFD .. 0xFFFF_FFFF_FFFF_FFFF, then 0, then 1 -> all matches; locked = 1 after the sample 1; no err.
- Gaps: samples 5, 6, 7, 8, 9 with 3 idle cycles between each -> same lock result as back-to-back; outputs hold during gaps.
- Simultaneous events: err_count = 3 and clear_err asserted in the same cycle as a LOCKED mismatch -> err_count = 1, err_sticky = 1. With clear_err alone -> err_count = 0, err_sticky = 0, locked unchanged.
- Reset mid-operation while LOCKED with err_sticky = 1 -> all outputs zero and exp_y = STEP. The next sample 500 is captured with no err; lock requires LOCK_N further matches.
